axil_pipe_slice: RTL and testbench



---
 rtl/axil_slice_pkg.sv | 26 ++
 rtl/axil_skid_stage.sv | 52 +++++
 rtl/axil_pipe_slice.sv | 201 ++++++++++++++++++++
 tb/tb_axil_pipe_slice.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_slice_pkg.sv
// Shared types and helpers for the AXI4-Lite pipeline slice.
package axil_slice_pkg;

    typedef logic [1:0] axil_resp_t;

    localparam axil_resp_t OKAY   = 2'b00;
    localparam axil_resp_t EXOKAY = 2'b01;
    localparam axil_resp_t SLVERR = 2'b10;
    localparam axil_resp_t DECERR = 2'b11;

    typedef struct packed {
        axil_resp_t resp;
    } axil_b_t;

    // R payload is width-generic; the top specialises the data field.
    localparam int MAX_DATA_WIDTH = 64;
    typedef struct packed {
        logic [MAX_DATA_WIDTH-1:0] data;
        axil_resp_t                resp;
    } axil_r_max_t;

    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

endpackage

// File: rtl/axil_skid_stage.sv
// One registered skid stage: main register plus a single-entry skid, ready is a pure flop output.
module axil_skid_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             push;
    logic             main_free;

    assign s_ready   = !skid_valid;
    assign push      = s_valid && !skid_valid;
    assign main_free = !main_valid || m_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            // NOTE: payload registers are reset as well so outputs are deterministic after reset.
            main_data  <= '0;
            skid_data  <= '0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= push;
                if (push) main_data <= s_data;
            end
        end else if (push) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
        end
    end

    assign m_valid = main_valid;
    assign m_data  = main_data;

endmodule

// File: rtl/axil_pipe_slice.sv
// AXI4-Lite register slice with per-direction outstanding limiters.
// Define AXIL_SLICE_STATS_EN to add completed-transaction counters.
module axil_pipe_slice
    import axil_slice_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int PIPE_LEVEL      = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic [7:0]              wr_outstanding,
    output logic [7:0]              rd_outstanding
`ifdef AXIL_SLICE_STATS_EN
    ,
    output logic [31:0]             stat_wr_done,
    output logic [31:0]             stat_rd_done
`endif
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CW         = cnt_width(MAX_OUTSTANDING);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
    } w_beat_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        axil_resp_t            resp;
    } r_beat_t;

    // Node 0 is the upstream end of each chain, node PIPE_LEVEL the downstream end.
    logic                  aw_v [PIPE_LEVEL+1];
    logic                  aw_r [PIPE_LEVEL+1];
    logic [ADDR_WIDTH-1:0] aw_d [PIPE_LEVEL+1];
    logic                  w_v  [PIPE_LEVEL+1];
    logic                  w_r  [PIPE_LEVEL+1];
    w_beat_t               w_d  [PIPE_LEVEL+1];
    logic                  b_v  [PIPE_LEVEL+1];
    logic                  b_r  [PIPE_LEVEL+1];
    axil_b_t               b_d  [PIPE_LEVEL+1];
    logic                  ar_v [PIPE_LEVEL+1];
    logic                  ar_r [PIPE_LEVEL+1];
    logic [ADDR_WIDTH-1:0] ar_d [PIPE_LEVEL+1];
    logic                  r_v  [PIPE_LEVEL+1];
    logic                  r_r  [PIPE_LEVEL+1];
    r_beat_t               r_d  [PIPE_LEVEL+1];

    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;
    logic          aw_ok;
    logic          ar_ok;
    logic          aw_fire;
    logic          b_fire;
    logic          ar_fire;
    logic          r_fire;

    for (genvar l = 0; l < PIPE_LEVEL; l++) begin : g_stage
        axil_skid_stage #(.WIDTH(ADDR_WIDTH)) u_aw (
            .clk(clk), .rst_n(rst_n),
            .s_valid(aw_v[l]), .s_ready(aw_r[l]), .s_data(aw_d[l]),
            .m_valid(aw_v[l+1]), .m_ready(aw_r[l+1]), .m_data(aw_d[l+1]));
        axil_skid_stage #(.WIDTH($bits(w_beat_t))) u_w (
            .clk(clk), .rst_n(rst_n),
            .s_valid(w_v[l]), .s_ready(w_r[l]), .s_data(w_d[l]),
            .m_valid(w_v[l+1]), .m_ready(w_r[l+1]), .m_data(w_d[l+1]));
        axil_skid_stage #(.WIDTH($bits(axil_b_t))) u_b (
            .clk(clk), .rst_n(rst_n),
            .s_valid(b_v[l]), .s_ready(b_r[l]), .s_data(b_d[l]),
            .m_valid(b_v[l+1]), .m_ready(b_r[l+1]), .m_data(b_d[l+1]));
        axil_skid_stage #(.WIDTH(ADDR_WIDTH)) u_ar (
            .clk(clk), .rst_n(rst_n),
            .s_valid(ar_v[l]), .s_ready(ar_r[l]), .s_data(ar_d[l]),
            .m_valid(ar_v[l+1]), .m_ready(ar_r[l+1]), .m_data(ar_d[l+1]));
        axil_skid_stage #(.WIDTH($bits(r_beat_t))) u_r (
            .clk(clk), .rst_n(rst_n),
            .s_valid(r_v[l]), .s_ready(r_r[l]), .s_data(r_d[l]),
            .m_valid(r_v[l+1]), .m_ready(r_r[l+1]), .m_data(r_d[l+1]));
    end

    // Limiter gate is a compare on a counter flop, keeping the ready path register-only.
    assign aw_ok = wr_cnt < MAX_CNT;
    assign ar_ok = rd_cnt < MAX_CNT;

    assign aw_v[0]              = s_awvalid && aw_ok;
    assign aw_d[0]              = s_awaddr;
    assign s_awready            = aw_r[0] && aw_ok;
    assign m_awvalid            = aw_v[PIPE_LEVEL];
    assign m_awaddr             = aw_d[PIPE_LEVEL];
    assign aw_r[PIPE_LEVEL]     = m_awready;

    assign w_v[0]               = s_wvalid;
    assign w_d[0]               = '{data: s_wdata, strb: s_wstrb};
    assign s_wready             = w_r[0];
    assign m_wvalid             = w_v[PIPE_LEVEL];
    assign m_wdata              = w_d[PIPE_LEVEL].data;
    assign m_wstrb              = w_d[PIPE_LEVEL].strb;
    assign w_r[PIPE_LEVEL]      = m_wready;

    assign b_v[0]               = m_bvalid;
    assign b_d[0]               = '{resp: m_bresp};
    assign m_bready             = b_r[0];
    assign s_bvalid             = b_v[PIPE_LEVEL];
    assign s_bresp              = b_d[PIPE_LEVEL].resp;
    assign b_r[PIPE_LEVEL]      = s_bready;

    assign ar_v[0]              = s_arvalid && ar_ok;
    assign ar_d[0]              = s_araddr;
    assign s_arready            = ar_r[0] && ar_ok;
    assign m_arvalid            = ar_v[PIPE_LEVEL];
    assign m_araddr             = ar_d[PIPE_LEVEL];
    assign ar_r[PIPE_LEVEL]     = m_arready;

    assign r_v[0]               = m_rvalid;
    assign r_d[0]               = '{data: m_rdata, resp: m_rresp};
    assign m_rready             = r_r[0];
    assign s_rvalid             = r_v[PIPE_LEVEL];
    assign s_rdata              = r_d[PIPE_LEVEL].data;
    assign s_rresp              = r_d[PIPE_LEVEL].resp;
    assign r_r[PIPE_LEVEL]      = s_rready;

    assign aw_fire = s_awvalid && s_awready;
    assign b_fire  = s_bvalid && s_bready;
    assign ar_fire = s_arvalid && s_arready;
    assign r_fire  = s_rvalid && s_rready;

    // Request and response in the same cycle cancel; a stray response never wraps below zero.
    function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cnt, input logic inc,
                                               input logic dec);
        if (inc && !dec) return cnt + CW'(1);
        if (dec && !inc && cnt != '0) return cnt - CW'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            wr_cnt <= cnt_next(wr_cnt, aw_fire, b_fire);
            rd_cnt <= cnt_next(rd_cnt, ar_fire, r_fire);
        end
    end

    assign wr_outstanding = 8'(wr_cnt);
    assign rd_outstanding = 8'(rd_cnt);

    a_no_b_underflow: assert property (@(posedge clk) disable iff (!rst_n) b_fire |-> wr_cnt != '0);
    a_no_r_underflow: assert property (@(posedge clk) disable iff (!rst_n) r_fire |-> rd_cnt != '0);

`ifdef AXIL_SLICE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_done <= '0;
            stat_rd_done <= '0;
        end else begin
            if (b_fire) stat_wr_done <= stat_wr_done + 32'd1;
            if (r_fire) stat_rd_done <= stat_rd_done + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axil_pipe_slice.sv
// Scoreboard bench for axil_pipe_slice; build with AXIL_SLICE_STATS_EN to cover the counters.
module tb_axil_pipe_slice;
    import axil_slice_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int PL = 3;
    localparam int MO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic          s_awvalid, s_awready, m_awvalid, m_awready;
    logic [DW-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [SW-1:0] s_wstrb, m_wstrb;
    logic          s_wvalid, s_wready, m_wvalid, m_wready;
    logic [1:0]    s_bresp, m_bresp, s_rresp, m_rresp;
    logic          s_bvalid, s_bready, m_bvalid, m_bready;
    logic          s_arvalid, s_arready, m_arvalid, m_arready;
    logic          s_rvalid, s_rready, m_rvalid, m_rready;
    logic [7:0]    wr_outstanding, rd_outstanding;
`ifdef AXIL_SLICE_STATS_EN
    logic [31:0]   stat_wr_done, stat_rd_done;
`endif

    axil_pipe_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPE_LEVEL(PL), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
`ifdef AXIL_SLICE_STATS_EN
        , .stat_wr_done(stat_wr_done), .stat_rd_done(stat_rd_done)
`endif
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_hs = 0;
    int b_hs_cyc = 0;
    int ar_beats = 0, ar_first = 0, ar_last = 0;

    logic [AW-1:0]    aw_q[$];
    logic [AW-1:0]    ar_q[$];
    logic [DW+SW-1:0] w_q[$];
    logic [1:0]       b_q[$];
    logic [DW+1:0]    r_q[$];

    typedef struct {
        logic [DW-1:0] rdata;
        axil_resp_t    rresp;
        logic [DW+1:0] exp_r;
    } vec_t;
    vec_t vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic extra_beat(input string name);
        total++;
        bad++;
        $display("FAIL %s: beat seen with nothing expected", name);
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: handshake wait expired", name);
    endtask

    // Output-side scoreboard, sampled mid-cycle while inputs are stable.
    always @(negedge clk) if (rst_n) begin
        if (m_awvalid && m_awready) begin
            if (aw_q.size() == 0) extra_beat("aw_extra");
            else check("aw_addr", 64'(m_awaddr), 64'(aw_q.pop_front()));
        end
        if (m_wvalid && m_wready) begin
            if (w_q.size() == 0) extra_beat("w_extra");
            else check("w_beat", 64'({m_wdata, m_wstrb}), 64'(w_q.pop_front()));
        end
        if (m_arvalid && m_arready) begin
            if (ar_beats == 0) ar_first = cyc;
            ar_last = cyc;
            ar_beats++;
            if (ar_q.size() == 0) extra_beat("ar_extra");
            else check("ar_addr", 64'(m_araddr), 64'(ar_q.pop_front()));
        end
        if (s_bvalid && s_bready) begin
            b_hs_cyc = cyc;
            if (b_q.size() == 0) extra_beat("b_extra");
            else check("b_resp", 64'(s_bresp), 64'(b_q.pop_front()));
        end
        if (s_rvalid && s_rready) begin
            if (r_q.size() == 0) extra_beat("r_extra");
            else check("r_beat", 64'({s_rdata, s_rresp}), 64'(r_q.pop_front()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_aw(input logic [AW-1:0] a);
        int k = 0;
        s_awaddr = a; s_awvalid = 1'b1;
        while (!s_awready && k < 100) begin step(); k++; end
        if (!s_awready) timeout("aw_wait");
        else begin aw_q.push_back(a); last_hs = cyc; end
        step(); s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
        int k = 0;
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        while (!s_wready && k < 100) begin step(); k++; end
        if (!s_wready) timeout("w_wait");
        else w_q.push_back({d, s});
        step(); s_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        int k = 0;
        s_araddr = a; s_arvalid = 1'b1;
        while (!s_arready && k < 100) begin step(); k++; end
        if (!s_arready) timeout("ar_wait");
        else begin ar_q.push_back(a); last_hs = cyc; end
        step(); s_arvalid = 1'b0;
    endtask

    task automatic send_b(input axil_resp_t r);
        int k = 0;
        m_bresp = r; m_bvalid = 1'b1;
        while (!m_bready && k < 100) begin step(); k++; end
        if (!m_bready) timeout("b_wait");
        else b_q.push_back(r);
        step(); m_bvalid = 1'b0;
    endtask

    task automatic send_r(input logic [DW-1:0] d, input axil_resp_t r, input logic [DW+1:0] exp);
        int k = 0;
        m_rdata = d; m_rresp = r; m_rvalid = 1'b1;
        while (!m_rready && k < 100) begin step(); k++; end
        if (!m_rready) timeout("r_wait");
        else r_q.push_back(exp);
        step(); m_rvalid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int k = 0;
        while ((aw_q.size() + w_q.size() + ar_q.size() + b_q.size() + r_q.size()) != 0 && k < 100) begin
            step(); k++;
        end
        check(name, 64'(aw_q.size() + w_q.size() + ar_q.size() + b_q.size() + r_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, hs15, hs, acc, k;

        vecs[0] = '{32'h0000_0000, OKAY,   {32'h0000_0000, OKAY}};
        vecs[1] = '{32'hDEAD_BEEF, EXOKAY, {32'hDEAD_BEEF, EXOKAY}};
        vecs[2] = '{32'h1234_5678, SLVERR, {32'h1234_5678, SLVERR}};
        vecs[3] = '{32'hFFFF_FFFF, DECERR, {32'hFFFF_FFFF, DECERR}};

        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
        s_araddr = '0; s_arvalid = 0; s_bready = 1; s_rready = 1;
        m_awready = 1; m_wready = 1; m_arready = 1;
        m_bresp = '0; m_bvalid = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
        step(2);
        rst_n = 1'b1;
        step();

        check("reset_readies", 64'({s_awready, s_wready, s_arready, m_bready, m_rready}), 64'h1F);
        check("reset_valids", 64'({m_awvalid, m_wvalid, m_arvalid, s_bvalid, s_rvalid}), 64'h0);
        check("reset_payload", 64'({m_awaddr, m_araddr} ^ {m_wdata, s_rdata}), 64'h0);
        check("reset_aux", 64'({m_wstrb, s_bresp, s_rresp}), 64'h0);
        check("reset_counts", 64'({wr_outstanding, rd_outstanding}), 64'h0);

        // Streaming: 16 back-to-back AR fill the read limit exactly.
        hs0 = 0; hs15 = 0;
        for (int i = 0; i < 16; i++) begin
            send_ar(32'(i * 4));
            if (i == 0) hs0 = last_hs;
            if (i == 15) hs15 = last_hs;
        end
        check("stream_in_no_bubble", 64'(hs15 - hs0), 64'd15);
        check("stream_limit_count", 64'(rd_outstanding), 64'(MO));
        check("stream_limit_ready", 64'(s_arready), 64'd0);
        step(PL + 1);
        check("stream_beats", 64'(ar_beats), 64'd16);
        check("stream_latency", 64'(ar_first - hs0), 64'(PL));
        check("stream_out_no_bubble", 64'(ar_last - ar_first), 64'd15);

        for (int i = 0; i < 16; i++) send_r(vecs[i % 4].rdata, vecs[i % 4].rresp, vecs[i % 4].exp_r);
        wait_empty("r_drain");
        check("r_drain_count", 64'(rd_outstanding), 64'd0);
        check("r_drain_arready", 64'(s_arready), 64'd1);

        // Backpressure on W: the chain absorbs two beats per stage.
        m_wready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            s_wvalid = 1'b1;
            s_wdata = 32'hA5A5_0000 + 32'(acc);
            s_wstrb = 4'(acc) ^ 4'hF;
            if (s_wready) begin w_q.push_back({s_wdata, s_wstrb}); acc++; end
            step();
        end
        s_wvalid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(2 * PL));
        check("bp_wready_low", 64'(s_wready), 64'd0);
        check("bp_held", 64'(w_q.size()), 64'(2 * PL));
        m_wready = 1'b1;
        wait_empty("bp_drain");
        check("bp_wready_back", 64'(s_wready), 64'd1);

        // Write limiter: B withheld until the limit stalls the next AW.
        for (int i = 0; i < MO; i++) send_aw(32'h1000 + 32'(i * 4));
        check("wlim_count", 64'(wr_outstanding), 64'(MO));
        check("wlim_ready_next", 64'(s_awready), 64'd0);
        s_awaddr = 32'h2000; s_awvalid = 1'b1;
        step(3);
        check("wlim_stalled", 64'({s_awready, wr_outstanding}), 64'(MO));
        send_b(SLVERR);
        k = 0; hs = 0;
        while (!s_awready && k < 50) begin step(); k++; end
        if (!s_awready) timeout("wlim_resume");
        else begin aw_q.push_back(32'h2000); hs = cyc; end
        step(); s_awvalid = 1'b0;
        check("wlim_resume_timing", 64'(hs - b_hs_cyc), 64'd1);
        for (int i = 0; i < MO; i++) send_b(OKAY);
        wait_empty("wlim_drain");
        check("wlim_drain_count", 64'(wr_outstanding), 64'd0);

        // AR and R handshakes in the same cycle leave the count unchanged.
        s_rready = 1'b0;
        send_ar(32'h40);
        send_r(32'h1111_2222, EXOKAY, {32'h1111_2222, EXOKAY});
        k = 0;
        while (!s_rvalid && k < 20) begin step(); k++; end
        check("sim_pre_count", 64'(rd_outstanding), 64'd1);
        s_araddr = 32'h44; s_arvalid = 1'b1; s_rready = 1'b1;
        check("sim_both_ready", 64'({s_arready, s_rvalid}), 64'h3);
        ar_q.push_back(32'h44);
        step();
        s_arvalid = 1'b0; s_rready = 1'b0;
        check("sim_count", 64'(rd_outstanding), 64'd1);
        s_rready = 1'b1;
        send_r(32'h3333_4444, OKAY, {32'h3333_4444, OKAY});
        wait_empty("sim_drain");
        check("sim_drain_count", 64'(rd_outstanding), 64'd0);

        // Reset with four beats parked in the R chain.
        s_rready = 1'b0;
        for (int i = 0; i < 4; i++) send_ar(32'h80 + 32'(i * 4));
        for (int i = 0; i < 4; i++) send_r(vecs[i].rdata, vecs[i].rresp, vecs[i].exp_r);
        step(PL + 2);
        check("rst_pre_state", 64'({s_rvalid, rd_outstanding}), 64'h104);
        rst_n = 1'b0;
        #1;
        check("rst_async_rvalid", 64'(s_rvalid), 64'd0);
        check("rst_async_counts", 64'({wr_outstanding, rd_outstanding}), 64'h0);
        aw_q.delete(); w_q.delete(); ar_q.delete(); b_q.delete(); r_q.delete();
        step();
        rst_n = 1'b1;
        s_rready = 1'b1;
        step();
        check("rst_post_readies", 64'({s_awready, s_wready, s_arready, m_bready, m_rready}), 64'h1F);
        check("rst_post_rvalid", 64'(s_rvalid), 64'd0);

        // Completed transactions: 5 writes and 7 reads.
        for (int i = 0; i < 5; i++) begin
            send_aw(32'h300 + 32'(i * 4));
            send_w(32'hC0DE_0000 + 32'(i), 4'(i + 1));
            send_b((i == 2) ? DECERR : OKAY);
        end
        for (int i = 0; i < 7; i++) begin
            send_ar(32'h400 + 32'(i * 4));
            send_r(vecs[i % 4].rdata, vecs[i % 4].rresp, vecs[i % 4].exp_r);
        end
        wait_empty("txn_drain");
        check("txn_counts", 64'({wr_outstanding, rd_outstanding}), 64'h0);
`ifdef AXIL_SLICE_STATS_EN
        check("stat_wr_done", 64'(stat_wr_done), 64'd5);
        check("stat_rd_done", 64'(stat_rd_done), 64'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
